// File: rtl/seq_cla_adder_if.sv
// Operand/result handshake bundle for seq_cla_adder.
// The sub signal exists only when SUBTRACT_EN is defined.
interface seq_cla_adder_if #(
  parameter int NUMBITS = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [NUMBITS-1:0] A;
  logic [NUMBITS-1:0] B;
  logic               carryin;
`ifdef SUBTRACT_EN
  logic               sub;
`endif
  logic               out_valid;
  logic               out_ready;
  logic [NUMBITS-1:0] result;
  logic               carryout;
  logic               busy;

`ifdef SUBTRACT_EN
  modport master (
    output in_valid, A, B, carryin, sub, out_ready,
    input  in_ready, out_valid, result, carryout, busy
  );
  modport slave (
    input  in_valid, A, B, carryin, sub, out_ready,
    output in_ready, out_valid, result, carryout, busy
  );
`else
  modport master (
    output in_valid, A, B, carryin, out_ready,
    input  in_ready, out_valid, result, carryout, busy
  );
  modport slave (
    input  in_valid, A, B, carryin, out_ready,
    output in_ready, out_valid, result, carryout, busy
  );
`endif
endinterface

// File: rtl/seq_cla_adder.sv
// Multi-cycle adder: one CHUNK-bit carry look-ahead slice per clock, carry registered between slices.
// Define SUBTRACT_EN to add the sub input (A - B via ~B with initial carry 1).
module seq_cla_adder #(
  parameter int NUMBITS = 32,
  parameter int CHUNK   = 8
) (
  input  logic           clk,
  input  logic           reset,
  seq_cla_adder_if.slave bus
);
  localparam int NSLICE = NUMBITS / CHUNK;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NSLICE - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state_reg, state_next;
  logic [NUMBITS-1:0] a_reg, b_reg, result_reg;
  logic               carry_reg, carryout_reg;
  logic [IDXW-1:0]    idx_reg;

  logic [31:0]        base;
  logic [CHUNK-1:0]   a_slice, b_slice, g, p, sum_slice, cout_bit;
  logic [NUMBITS-1:0] b_eff;
  logic               carry_init;

`ifdef SUBTRACT_EN
  assign b_eff      = bus.sub ? ~bus.B : bus.B;
  assign carry_init = bus.sub ? 1'b1 : bus.carryin;
`else
  assign b_eff      = bus.B;
  assign carry_init = bus.carryin;
`endif

  assign base    = 32'(idx_reg) * CHUNK;
  assign a_slice = a_reg[base +: CHUNK];
  assign b_slice = b_reg[base +: CHUNK];
  assign g       = a_slice & b_slice;
  assign p       = a_slice ^ b_slice;

  // Each slice carry is the flattened look-ahead sum of products, not a ripple chain.
  generate
    for (genvar gi = 0; gi < CHUNK; gi++) begin : g_cla
      logic cbit;
      always_comb begin
        logic term;
        cbit = g[gi];
        term = p[gi];
        for (int j = gi - 1; j >= 0; j--) begin
          cbit = cbit | (term & g[j]);
          term = term & p[j];
        end
        cbit = cbit | (term & carry_reg);
      end
      assign cout_bit[gi] = cbit;
      if (gi == 0) begin : g_lsb
        assign sum_slice[gi] = p[gi] ^ carry_reg;
      end else begin : g_upper
        assign sum_slice[gi] = p[gi] ^ cout_bit[gi-1];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.in_valid) state_next = RUN;
      RUN:     if (idx_reg == LAST_IDX) state_next = DONE;
      DONE:    if (bus.out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_reg        <= '0;
      b_reg        <= '0;
      result_reg   <= '0;
      carry_reg    <= 1'b0;
      carryout_reg <= 1'b0;
      idx_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg     <= bus.A;
            b_reg     <= b_eff;
            carry_reg <= carry_init;
            idx_reg   <= '0;
          end
        end
        RUN: begin
          result_reg[base +: CHUNK] <= sum_slice;
          carry_reg                 <= cout_bit[CHUNK-1];
          if (idx_reg == LAST_IDX) begin
            carryout_reg <= cout_bit[CHUNK-1];
            idx_reg      <= '0;
          end else begin
            idx_reg <= idx_reg + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Gated by reset so in_ready reads 0 while reset is held.
  assign bus.in_ready  = (state_reg == IDLE) && reset;
  assign bus.out_valid = (state_reg == DONE);
  assign bus.busy      = (state_reg != IDLE);
  assign bus.result    = result_reg;
  assign bus.carryout  = carryout_reg;
endmodule

// File: tb/tb_seq_cla_adder.sv
// Scoreboard bench for seq_cla_adder: random and directed operations against an arithmetic model.
module tb_seq_cla_adder;
  localparam int NB = 32;
  localparam int CH = 8;
  localparam int NS = NB / CH;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  seq_cla_adder_if #(.NUMBITS(NB)) u_if ();
  seq_cla_adder_if #(.NUMBITS(8))  u_if8 ();

  seq_cla_adder #(.NUMBITS(NB), .CHUNK(CH)) dut  (.clk(clk), .reset(reset), .bus(u_if.slave));
  seq_cla_adder #(.NUMBITS(8),  .CHUNK(4))  dut8 (.clk(clk), .reset(reset), .bus(u_if8.slave));

  typedef struct {
    logic [NB-1:0] r;
    logic          c;
    int            acc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   txn = 0;
  bit   seen = 0;
  bit   rand_mode = 0;
  logic forced_ready = 1'b1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: plain wide arithmetic; subtraction reports carryout as "no borrow".
  function automatic void model(input logic [NB-1:0] a, input logic [NB-1:0] b,
                                input logic cin, input logic sb,
                                output logic [NB-1:0] r, output logic c);
    logic [NB:0] s;
    if (sb) begin
      r = a - b;
      c = (a >= b);
    end else begin
      s = {1'b0, a} + {1'b0, b} + (NB+1)'(cin);
      r = s[NB-1:0];
      c = s[NB];
    end
  endfunction

  task automatic do_op(input logic [NB-1:0] a, input logic [NB-1:0] b,
                       input logic cin, input logic sb, input bit push);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    while (!u_if.in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!u_if.in_ready) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: in_ready got 0 expected 1");
      return;
    end
    u_if.in_valid = 1'b1;
    u_if.A        = a;
    u_if.B        = b;
    u_if.carryin  = cin;
`ifdef SUBTRACT_EN
    u_if.sub      = sb;
`endif
    @(posedge clk);
    #1;
    u_if.in_valid = 1'b0;
    u_if.A        = NB'($urandom);
    u_if.B        = NB'($urandom);
    u_if.carryin  = 1'($urandom);
    if (push) begin
      model(a, b, cin, sb, e.r, e.c);
      e.acc = cyc;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((exp_q.size() != 0 || u_if.busy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy got %0b expected 0", u_if.busy);
    end
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                     input logic [7:0] er, input logic ec);
    int n = 0;
    @(negedge clk);
    while (!u_if8.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    u_if8.in_valid = 1'b1;
    u_if8.A        = a;
    u_if8.B        = b;
    u_if8.carryin  = cin;
    @(posedge clk);
    #1;
    u_if8.in_valid = 1'b0;
    n = 0;
    while (!u_if8.out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("lat8", 64'(n), 64'd2);
    check("result8", 64'(u_if8.result), 64'(er));
    check("carryout8", 64'(u_if8.carryout), 64'(ec));
    $display("op8 %h+%h+%0b: result=%h carryout=%0b latency=%0d", a, b, cin, u_if8.result, u_if8.carryout, n);
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops the scoreboard on every output handshake.
  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      seen = 0;
    end else if (u_if.out_valid) begin
      if (!seen) begin
        seen = 1;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out_valid: out_valid got 1 expected 0");
        end else begin
          check("latency", 64'(cyc - exp_q[0].acc), 64'(NS));
        end
      end
      if (u_if.out_ready) begin
        seen = 0;
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("result", 64'(u_if.result), 64'(e.r));
          check("carryout", 64'(u_if.carryout), 64'(e.c));
          txn++;
          $display("txn %0d: result=%h carryout=%0b expected %h/%0b", txn, u_if.result, u_if.carryout, e.r, e.c);
        end
      end
    end
  end

  initial begin
    u_if.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      u_if.out_ready = rand_mode ? ($urandom_range(0, 3) != 0) : forced_ready;
    end
  end

  initial begin
    logic [NB-1:0] ra, rb;
    int n;
    u_if.in_valid = 1'b0; u_if.A = '0; u_if.B = '0; u_if.carryin = 1'b0;
    u_if8.in_valid = 1'b0; u_if8.A = '0; u_if8.B = '0; u_if8.carryin = 1'b0;
    u_if8.out_ready = 1'b1;
`ifdef SUBTRACT_EN
    u_if.sub = 1'b0;
    u_if8.sub = 1'b0;
`endif
    #3;
    check("rst_in_ready", 64'(u_if.in_ready), 64'd0);
    check("rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("rst_busy", 64'(u_if.busy), 64'd0);
    check("rst_result", 64'(u_if.result), 64'd0);
    check("rst_carryout", 64'(u_if.carryout), 64'd0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_in_ready", 64'(u_if.in_ready), 64'd1);

    // Full-width carry chain, in_ready low across RUN.
    do_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1);
    for (int i = 0; i < NS - 1; i++) begin
      check("run_in_ready", 64'(u_if.in_ready), 64'd0);
      check("run_busy", 64'(u_if.busy), 64'd1);
      @(posedge clk);
      #1;
    end
    wait_idle();
    do_op(32'h7FFF_FFFF, 32'h0, 1'b1, 1'b0, 1);
    wait_idle();

    // Backpressure: result holds and a new request is ignored.
    forced_ready = 1'b0;
    @(posedge clk);
    #3;
    do_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0, 1);
    n = 0;
    while (!u_if.out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      u_if.in_valid = 1'b1;
      u_if.A = NB'($urandom);
      u_if.B = NB'($urandom);
      if (exp_q.size() != 0) begin
        check("hold_result", 64'(u_if.result), 64'(exp_q[0].r));
        check("hold_carryout", 64'(u_if.carryout), 64'(exp_q[0].c));
      end
      check("hold_out_valid", 64'(u_if.out_valid), 64'd1);
      check("hold_in_ready", 64'(u_if.in_ready), 64'd0);
    end
    @(negedge clk);
    u_if.in_valid = 1'b0;
    forced_ready = 1'b1;
    n = 0;
    while (u_if.out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("release_in_ready", 64'(u_if.in_ready), 64'd1);
    do_op(32'hCAFE_0001, 32'h0000_FFFF, 1'b0, 1'b0, 1);
    wait_idle();

    // Random traffic with random output backpressure.
    rand_mode = 1;
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0: ra = '1;
        1: ra = '0;
        default: ra = NB'($urandom);
      endcase
      rb = ($urandom_range(0, 3) == 0) ? '1 : NB'($urandom);
`ifdef SUBTRACT_EN
      do_op(ra, rb, 1'($urandom), 1'($urandom), 1);
`else
      do_op(ra, rb, 1'($urandom), 1'b0, 1);
`endif
    end
    wait_idle();
    rand_mode = 0;
    forced_ready = 1'b1;

`ifdef SUBTRACT_EN
    do_op(32'd7, 32'd5, 1'b0, 1'b1, 1);
    do_op(32'd5, 32'd7, 1'b1, 1'b1, 1);
    do_op(32'd0, 32'd0, 1'b0, 1'b1, 1);
    wait_idle();
`endif

    // Reset two cycles into RUN discards the operation.
    do_op(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("mid_rst_out_valid", 64'(u_if.out_valid), 64'd0);
    check("mid_rst_busy", 64'(u_if.busy), 64'd0);
    check("mid_rst_result", 64'(u_if.result), 64'd0);
    check("mid_rst_carryout", 64'(u_if.carryout), 64'd0);
    check("mid_rst_in_ready", 64'(u_if.in_ready), 64'd0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("after_rst_in_ready", 64'(u_if.in_ready), 64'd1);
    check("after_rst_busy", 64'(u_if.busy), 64'd0);
    repeat (10) @(posedge clk);
    do_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, 1);
    wait_idle();

    // Narrow instance, two slices.
    op8(8'hD5, 8'h64, 1'b0, 8'h39, 1'b1);
    op8(8'h0B, 8'h0B, 1'b0, 8'h16, 1'b0);
    op8(8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
